// File: rtl/i2c_pkg.sv
// Shared types and constants for the single-byte I2C write controller.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        ADDR,
        ACK_A,
        DATA,
        ACK_D,
        STOP
    } state_t;

    // Position within one SCL bit; each bit is four divider ticks long.
    localparam logic [1:0] Q_SET    = 2'd0;
    localparam logic [1:0] Q_RISE   = 2'd1;
    localparam logic [1:0] Q_SAMPLE = 2'd2;
    localparam logic [1:0] Q_FALL   = 2'd3;

    localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-bit tick generator: one tick every CLK_DIV+1 clocks, restartable by clear.
module i2c_tick_gen #(
    parameter int CLK_DIV = 63
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int DW = (CLK_DIV < 1) ? 1 : $clog2(CLK_DIV + 1);
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV);

    logic [DW-1:0] div;

    assign tick = (div == DIV_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n || clear || tick) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

endmodule

// File: rtl/i2c_write_master.sv
// I2C initiator: START, 7-bit address + W, one data byte, STOP on open-drain SCL/SDA.
// Handshake: start is taken only in IDLE and not in the done cycle; busy covers accept+1 .. done-1.
module i2c_write_master
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 63
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic [7:0] data,
    input  logic       sda_in,
    output logic       scl_oe,
    output logic       sda_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err
);

    state_t      state, state_nxt;
    logic [1:0]  q, q_nxt;
    logic [2:0]  bit_cnt, bit_cnt_nxt;
    logic [7:0]  shift, shift_nxt;
    logic [7:0]  data_lat, data_lat_nxt;
    logic        scl_nxt, sda_nxt, ack_err_nxt, done_nxt;
    logic [1:0]  sda_sync;
    logic        tick;
    logic        accept;

    assign accept = (state == IDLE) && start && !done;
    assign busy   = (state != IDLE);

    i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (accept),
        .tick  (tick)
    );

    // The ACK level is only sampled a quarter bit after SCL rises, so the synchroniser delay is harmless.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sda_sync <= 2'b11;
        end else begin
            sda_sync <= {sda_sync[0], sda_in};
        end
    end

    always_comb begin
        state_nxt    = state;
        q_nxt        = q;
        bit_cnt_nxt  = bit_cnt;
        shift_nxt    = shift;
        data_lat_nxt = data_lat;
        scl_nxt      = scl_oe;
        sda_nxt      = sda_oe;
        ack_err_nxt  = ack_err;
        done_nxt     = 1'b0;

        if (state == IDLE) begin
            if (accept) begin
                shift_nxt    = {addr, RW_WRITE};
                data_lat_nxt = data;
                ack_err_nxt  = 1'b0;
                q_nxt        = Q_SET;
                bit_cnt_nxt  = 3'd0;
                state_nxt    = START;
            end
        end else if (tick) begin
            q_nxt = q + 2'd1;
            case (state)
                START: begin
                    case (q)
                        Q_SET:  begin scl_nxt = 1'b0; sda_nxt = 1'b0; end
                        Q_RISE: sda_nxt = 1'b1;
                        Q_FALL: begin scl_nxt = 1'b1; state_nxt = ADDR; end
                        default: ;
                    endcase
                end
                ADDR, DATA: begin
                    case (q)
                        Q_SET:  sda_nxt = ~shift[7];
                        Q_RISE: scl_nxt = 1'b0;
                        Q_FALL: begin
                            scl_nxt     = 1'b1;
                            shift_nxt   = {shift[6:0], 1'b0};
                            bit_cnt_nxt = bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                state_nxt = (state == ADDR) ? ACK_A : ACK_D;
                            end
                        end
                        default: ;
                    endcase
                end
                ACK_A, ACK_D: begin
                    case (q)
                        Q_SET:    sda_nxt = 1'b0;
                        Q_RISE:   scl_nxt = 1'b0;
                        Q_SAMPLE: if (sda_sync[1]) ack_err_nxt = 1'b1;
                        Q_FALL: begin
                            scl_nxt = 1'b1;
                            // An address NACK skips the data byte entirely.
                            if (state == ACK_A && !ack_err) begin
                                shift_nxt = data_lat;
                                state_nxt = DATA;
                            end else begin
                                state_nxt = STOP;
                            end
                        end
                        default: ;
                    endcase
                end
                STOP: begin
                    case (q)
                        Q_SET:    begin scl_nxt = 1'b1; sda_nxt = 1'b1; end
                        Q_RISE:   scl_nxt = 1'b0;
                        Q_SAMPLE: sda_nxt = 1'b0;
                        Q_FALL:   begin state_nxt = IDLE; done_nxt = 1'b1; end
                        default: ;
                    endcase
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            q        <= Q_SET;
            bit_cnt  <= 3'd0;
            shift    <= 8'd0;
            data_lat <= 8'd0;
            scl_oe   <= 1'b0;
            sda_oe   <= 1'b0;
            ack_err  <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            q        <= q_nxt;
            bit_cnt  <= bit_cnt_nxt;
            shift    <= shift_nxt;
            data_lat <= data_lat_nxt;
            scl_oe   <= scl_nxt;
            sda_oe   <= sda_nxt;
            ack_err  <= ack_err_nxt;
            done     <= done_nxt;
        end
    end

endmodule

// File: tb/tb_i2c_write_master.sv
// Bench for i2c_write_master: open-drain bus, ACKing target model, byte scoreboard, protocol check.
module tb_i2c_write_master;

  localparam int CLK_DIV = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [6:0] addr = 7'd0;
  logic [7:0] data = 8'd0;
  logic       sda_in;
  logic       scl_oe, sda_oe, busy, done, ack_err;

  logic tgt_sda_oe = 1'b0;
  logic scl_bus, sda_bus;

  assign scl_bus = ~scl_oe;
  assign sda_bus = ~(sda_oe | tgt_sda_oe);
  assign sda_in  = sda_bus;

  i2c_write_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .addr    (addr),
    .data    (data),
    .sda_in  (sda_in),
    .scl_oe  (scl_oe),
    .sda_oe  (sda_oe),
    .busy    (busy),
    .done    (done),
    .ack_err (ack_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard of bytes the target should see on the bus
  logic [7:0] exp_q[$];

  // target model
  bit         tgt_ack_addr = 1'b1;
  bit         tgt_ack_data = 1'b1;
  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;
  bit         in_frame = 1'b0;
  int         bit_n = 0;
  int         byte_idx = 0;
  logic [7:0] shreg = 8'd0;
  int         start_count = 0;
  int         stop_count = 0;
  int         rise_count = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_frame   = 1'b0;
        tgt_sda_oe = 1'b0;
      end else if (prev_scl === 1'b1 && scl_bus === 1'b1 && prev_sda === 1'b1 && sda_bus === 1'b0) begin
        start_count++;
        in_frame = 1'b1;
        bit_n    = 0;
        byte_idx = 0;
      end else if (prev_scl === 1'b1 && scl_bus === 1'b1 && prev_sda === 1'b0 && sda_bus === 1'b1) begin
        stop_count++;
        check_val("stop_at_boundary", 32'(in_frame && byte_idx >= 1 && bit_n <= 1), 32'd1);
        in_frame   = 1'b0;
        tgt_sda_oe = 1'b0;
      end else if (in_frame && prev_scl === 1'b0 && scl_bus === 1'b1) begin
        rise_count++;
        if (bit_n < 8) begin
          shreg = {shreg[6:0], sda_bus};
          bit_n++;
          if (bit_n == 8) begin
            check_val("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) check_val("bus_byte", 32'(shreg), 32'(exp_q.pop_front()));
          end
        end else begin
          bit_n = 0;
          byte_idx++;
        end
      end else if (in_frame && prev_scl === 1'b1 && scl_bus === 1'b0) begin
        if (bit_n == 8) tgt_sda_oe = (byte_idx == 0) ? tgt_ack_addr : tgt_ack_data;
        else if (bit_n == 0) tgt_sda_oe = 1'b0;
      end
      prev_scl = scl_bus;
      prev_sda = sda_bus;
    end
  end

  // driver: one request, optional second start, optional mid-frame reset, optional start in done cycle
  task automatic run_txn(input logic [6:0] a, input logic [7:0] d, input bit ack_a, input bit ack_d,
                         input int exp_done, input int start2_at, input int rst_at,
                         input bit probe_done_start);
    int s0, p0, r0, cyc;
    bit busy_gap;
    tgt_ack_addr = ack_a;
    tgt_ack_data = ack_d;
    if (rst_at == 0) begin
      exp_q.push_back({a, 1'b0});
      if (ack_a) exp_q.push_back(d);
    end
    s0 = start_count;
    p0 = stop_count;
    r0 = rise_count;
    @(posedge clk); #1;
    start = 1'b1;
    addr  = a;
    data  = d;
    @(posedge clk); #1;
    start = 1'b0;
    addr  = 7'($urandom_range(0, 127));
    data  = 8'($urandom_range(0, 255));
    cyc = 1;
    check_val("busy_after_accept", 32'(busy), 32'd1);
    check_val("ack_err_cleared", 32'(ack_err), 32'd0);
    busy_gap = 1'b0;
    while (!done && cyc < 1000) begin
      if (!busy) busy_gap = 1'b1;
      start = (cyc == start2_at);
      if (rst_at != 0 && cyc == rst_at) rst_n = 1'b0;
      @(posedge clk); #1;
      cyc++;
      if (rst_at != 0 && cyc == rst_at + 1) break;
    end
    start = 1'b0;
    if (rst_at != 0) begin
      check_val("rst_scl_oe", 32'(scl_oe), 32'd0);
      check_val("rst_sda_oe", 32'(sda_oe), 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      check_val("rst_no_stop", 32'(stop_count - p0), 32'd0);
      check_val("rst_idle", 32'(busy), 32'd0);
      exp_q.delete();
      return;
    end
    check_val("done_cycle", 32'(cyc), 32'(exp_done));
    check_val("busy_at_done", 32'(busy), 32'd0);
    check_val("busy_held", 32'(busy_gap), 32'd0);
    check_val("ack_err", 32'(ack_err), 32'(!(ack_a && ack_d)));
    if (probe_done_start) begin
      start = 1'b1;
      addr  = a;
    end
    @(posedge clk); #1;
    start = 1'b0;
    check_val("done_one_cycle", 32'(done), 32'd0);
    check_val("busy_after_done", 32'(busy), 32'd0);
    check_val("scl_released", 32'(scl_oe), 32'd0);
    check_val("sda_released", 32'(sda_oe), 32'd0);
    check_val("ack_err_held", 32'(ack_err), 32'(!(ack_a && ack_d)));
    check_val("start_cnt", 32'(start_count - s0), 32'd1);
    check_val("stop_cnt", 32'(stop_count - p0), 32'd1);
    check_val("scl_rises", 32'(rise_count - r0), ack_a ? 32'd19 : 32'd10);
    check_val("sb_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    repeat (4) @(posedge clk);
    #1;
    check_val("reset_scl_oe", 32'(scl_oe), 32'd0);
    check_val("reset_sda_oe", 32'(sda_oe), 32'd0);
    check_val("reset_busy", 32'(busy), 32'd0);
    check_val("reset_done", 32'(done), 32'd0);
    check_val("reset_ack_err", 32'(ack_err), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    run_txn(7'h3C, 8'h5A, 1'b1, 1'b1, 321, 0, 0, 1'b0);
    run_txn(7'h21, 8'hC3, 1'b0, 1'b0, 177, 0, 0, 1'b0);
    run_txn(7'h3C, 8'hFF, 1'b1, 1'b0, 321, 0, 0, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    check_val("ack_err_idle_hold", 32'(ack_err), 32'd1);
    run_txn(7'h3C, 8'h5A, 1'b1, 1'b1, 321, 50, 0, 1'b0);
    run_txn(7'h3C, 8'h5A, 1'b1, 1'b1, 0, 0, 100, 1'b0);
    run_txn(7'h55, 8'h0F, 1'b1, 1'b1, 321, 0, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      run_txn(7'($urandom_range(0, 127)), 8'($urandom_range(0, 255)), 1'b1, 1'b1, 321, 0, 0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
